mem_responder: RTL and testbench

- Synthesizable main-memory endpoint that sits on the far side of the riscv_arbiter's mem_req/mem_resp interface.
- Accepts tagged read/write line requests and consumes write-data beats with byte masks.
- Returns read data as tagged beat bursts from an internal banked array.
- Used for simulation and FPGA bring-up in place of the external memory model.

---
 rtl/mem151_pkg.sv | 21 ++
 rtl/mem_responder_ram.sv | 37 +++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem151_pkg.sv
// Shared definitions for the mem_responder slice: FSM encoding, bus width defaults,
// line geometry and the backpressure LFSR constants.
package mem151_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        RWAIT  = 2'd2,
        RBURST = 2'd3
    } state_t;

    localparam int MEM_ADDR_BITS_DFLT = 28;
    localparam int MEM_DATA_BITS_DFLT = 128;
    localparam int MEM_TAG_BITS_DFLT  = 5;
    localparam int MEM_BEATS          = 4;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port line storage: one byte-lane array per byte, registered read,
// byte-masked write; a write cycle performs no read.
module mem_responder_ram #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DATA_BITS/8-1:0] be,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [DATA_BITS-1:0]   wdata,
    output logic [DATA_BITS-1:0]   rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Separate arrays per lane keep each lane a plain single-writer RAM.
    generate
        for (genvar gi = 0; gi < DATA_BITS/8; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (we) begin
                    if (be[gi]) begin
                        lane_mem[addr] <= wdata[gi*8 +: 8];
                    end
                end else begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory endpoint: one outstanding tagged line request, write beats with byte masks,
// fixed-latency contiguous read bursts. Optional MEM_BACKPRESSURE_EN gates readies with an LFSR.
module mem_responder
    import mem151_pkg::*;
#(
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DFLT,
    parameter int MEM_DATA_BITS = MEM_DATA_BITS_DFLT,
    parameter int MEM_TAG_BITS  = MEM_TAG_BITS_DFLT,
    parameter int BEATS         = MEM_BEATS,
    parameter int LINE_IDX_BITS = 10,
    parameter int RD_LATENCY    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic                       mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data,
    output logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);

    localparam int BEAT_BITS = $clog2(BEATS);
    localparam int RAM_AW    = LINE_IDX_BITS + BEAT_BITS;
    localparam int CNT_BITS  = $clog2(RD_LATENCY + 1);

    state_t                     state_reg, state_next;
    logic [LINE_IDX_BITS-1:0]   line_reg, line_next;
    logic [MEM_TAG_BITS-1:0]    tag_reg, tag_next;
    logic [BEAT_BITS-1:0]       beat_reg, beat_next;
    logic [CNT_BITS-1:0]        cnt_reg, cnt_next;

    logic                       gate_req, gate_data;
    logic                       req_fire, data_fire;
    logic                       ram_we;
    logic [RAM_AW-1:0]          ram_addr;
    logic [MEM_DATA_BITS-1:0]   ram_rdata;

    // Upper address bits alias onto the same storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:LINE_IDX_BITS];

`ifdef MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_reg, lfsr_next;

    always_comb begin
        lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign gate_req  = lfsr_reg[0];
    assign gate_data = lfsr_reg[1];
`else
    assign gate_req  = 1'b1;
    assign gate_data = 1'b1;
`endif

    assign req_fire  = mem_req_valid & mem_req_ready;
    assign data_fire = mem_req_data_valid & mem_req_data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            line_reg  <= '0;
            tag_reg   <= '0;
            beat_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            line_reg  <= line_next;
            tag_reg   <= tag_next;
            beat_reg  <= beat_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The wait counter leaves RWAIT one cycle early so that beat 0 lands exactly
    // RD_LATENCY cycles after the handshake; latency 1 skips RWAIT entirely.
    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        tag_next   = tag_reg;
        beat_next  = beat_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) begin
                    line_next = mem_req_addr[LINE_IDX_BITS-1:0];
                    tag_next  = mem_req_tag;
                    beat_next = '0;
                    if (mem_req_rw) begin
                        state_next = WDATA;
                    end else if (RD_LATENCY == 1) begin
                        state_next = RBURST;
                    end else begin
                        state_next = RWAIT;
                        cnt_next   = CNT_BITS'(RD_LATENCY - 1);
                    end
                end
            end
            WDATA: begin
                if (data_fire) begin
                    beat_next = BEAT_BITS'(beat_reg + 1'b1);
                    if (beat_reg == BEAT_BITS'(BEATS - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            RWAIT: begin
                if (cnt_reg == CNT_BITS'(1)) begin
                    state_next = RBURST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = CNT_BITS'(cnt_reg - 1'b1);
                end
            end
            RBURST: begin
                beat_next = BEAT_BITS'(beat_reg + 1'b1);
                if (beat_reg == BEAT_BITS'(BEATS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_ready      = (state_reg == IDLE) & gate_req;
        mem_req_data_ready = (state_reg == WDATA) & gate_data;
        mem_resp_valid     = (state_reg == RBURST);
        mem_resp_tag       = mem_resp_valid ? tag_reg : '0;
        mem_resp_data      = mem_resp_valid ? ram_rdata : '0;
    end

    // Storage is read one cycle ahead of each beat: beat 0 during the cycle before
    // the burst, beat k+1 while beat k is on the bus.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {line_reg, BEAT_BITS'(0)};
        case (state_reg)
            IDLE:   ram_addr = {mem_req_addr[LINE_IDX_BITS-1:0], BEAT_BITS'(0)};
            WDATA: begin
                ram_we   = data_fire;
                ram_addr = {line_reg, beat_reg};
            end
            RWAIT:  ram_addr = {line_reg, BEAT_BITS'(0)};
            RBURST: ram_addr = {line_reg, BEAT_BITS'(beat_reg + 1'b1)};
            default: ram_addr = {line_reg, BEAT_BITS'(0)};
        endcase
    end

    mem_responder_ram #(
        .ADDR_BITS (RAM_AW),
        .DATA_BITS (MEM_DATA_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (mem_req_data_mask),
        .addr  (ram_addr),
        .wdata (mem_req_data_bits),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand sequences for back-to-back reads
// and reset mid-burst, then random traffic checked against a line-array scoreboard.
module tb_mem_responder;

    localparam int L      = 6;
    localparam int BUDGET = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid, mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;

    mem_responder dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [4:0]   tag;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        bit                 rw;
        logic [27:0]        addr;
        logic [4:0]         tag;
        logic [3:0][127:0]  d;
        logic [3:0][15:0]   m;
        int                 gap_beat;
        logic [3:0][127:0]  e;
    } vec_t;

    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    bit           in_write = 1'b0;
    exp_t         exp_q[$];
    logic [127:0] model [0:1023][0:3];
    vec_t         vecs[8];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [3:0][127:0] mk4(input logic [127:0] b0, input logic [127:0] b1,
                                              input logic [127:0] b2, input logic [127:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Response monitor: every beat must match the head of the expectation queue in cycle, tag and data.
    initial forever begin
        @(negedge clk);
        if (mem_resp_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: cyc=%0d tag=%0d data=%h required no beat", cyc, mem_resp_tag, mem_resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.tag !== mem_resp_tag || e.data !== mem_resp_data) begin
                    mismatched++;
                    $display("FAIL resp_beat: cyc=%0d tag=%0d data=%h required cyc=%0d tag=%0d data=%h",
                             cyc, mem_resp_tag, mem_resp_data, e.cyc, e.tag, e.data);
                end else begin
                    $display("beat ok cyc=%0d tag=%0d data=%h", cyc, mem_resp_tag, mem_resp_data);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_beat: cyc=%0d resp_valid=0 required beat tag=%0d at cyc=%0d", cyc, exp_q[0].tag, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (!in_write && !reset && mem_req_data_ready) begin
            compared++;
            mismatched++;
            $display("FAIL data_ready_outside_write: cyc=%0d got 1 required 0", cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Caller is just after a posedge. Returns just after the posedge following the handshake.
    task automatic issue(input logic rw, input logic [27:0] addr, input logic [4:0] tag,
                         input bit use_exp, input logic [3:0][127:0] e, output int hs, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        hs = -1;
        mem_req_valid = 1'b1;
        mem_req_rw    = rw;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        if (rw) begin
            mem_req_data_valid = 1'b0;
        end else begin
            mem_req_data_valid = 1'($urandom % 2);
            mem_req_data_bits  = rnd128();
            mem_req_data_mask  = 16'($urandom);
        end
        forever begin
            @(negedge clk);
            if (mem_req_ready) break;
            n++;
            if (n > BUDGET) begin
                compared++;
                mismatched++;
                $display("FAIL req_ready_timeout: waited %0d cycles required handshake", n);
                mem_req_valid      = 1'b0;
                mem_req_data_valid = 1'b0;
                return;
            end
        end
        hs = cyc;
        if (!rw) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{cyc + L + k, tag, use_exp ? e[k] : model[addr[9:0]][k]});
            end
        end
        $display("req %s addr=%h tag=%0d hs_cyc=%0d", rw ? "WR" : "RD", addr, tag, hs);
        @(posedge clk);
        #1;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        in_write           = rw;
        ok                 = 1'b1;
    endtask

    task automatic ready_low(input string name);
        compared++;
        if (mem_req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: mem_req_ready=%b required 0 cyc=%0d", name, mem_req_ready, cyc);
        end
    endtask

    task automatic do_write(input logic [27:0] addr, input logic [3:0][127:0] d,
                            input logic [3:0][15:0] m, input int gap_beat);
        bit ok;
        int hs, n, line;
        logic [3:0][127:0] none;
        none = '0;
        issue(1'b1, addr, 5'd0, 1'b0, none, hs, ok);
        if (!ok) return;
        line = int'(addr[9:0]);
        for (int b = 0; b < 4; b++) begin
            if (b == gap_beat) begin
                mem_req_data_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    ready_low("ready_in_gap");
                    @(posedge clk);
                    #1;
                end
            end
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = d[b];
            mem_req_data_mask  = m[b];
            n = 0;
            forever begin
                @(negedge clk);
                ready_low("ready_in_wdata");
                if (mem_req_data_ready) break;
                n++;
                if (n > BUDGET) begin
                    compared++;
                    mismatched++;
                    $display("FAIL data_ready_timeout: beat %0d waited %0d cycles", b, n);
                    mem_req_data_valid = 1'b0;
                    in_write = 1'b0;
                    return;
                end
            end
            for (int y = 0; y < 16; y++) begin
                if (m[b][y]) model[line][b][y*8 +: 8] = d[b][y*8 +: 8];
            end
            @(posedge clk);
            #1;
        end
        mem_req_data_valid = 1'b0;
        in_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            #1;
            n++;
            if (n > BUDGET) begin
                compared++;
                mismatched++;
                $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs1, hs2, hs3;
        bit ok;
        logic [3:0][127:0] none;
        logic [9:0] lines[8];
        none = '0;

        vecs[0] = '{1'b1, 28'h10, 5'd0,
                    mk4({16{8'h11}}, {16{8'h22}}, {16{8'h33}}, {16{8'h44}}),
                    {4{16'hFFFF}}, -1, none};
        vecs[1] = '{1'b0, 28'h10, 5'd5, none, '0, -1,
                    mk4({16{8'h11}}, {16{8'h22}}, {16{8'h33}}, {16{8'h44}})};
        vecs[2] = '{1'b1, 28'h10, 5'd0, mk4({16{8'hFF}}, {16{8'hFF}}, {16{8'hFF}}, {16{8'hFF}}),
                    {16'h0000, 16'h0000, 16'h0001, 16'h0000}, 2, none};
        vecs[3] = '{1'b0, 28'h10, 5'd5, none, '0, -1,
                    mk4({16{8'h11}}, {{15{8'h22}}, 8'hFF}, {16{8'h33}}, {16{8'h44}})};
        vecs[4] = '{1'b1, 28'h410, 5'd0, mk4({16{8'h55}}, {16{8'h55}}, {16{8'h55}}, {16{8'h55}}),
                    {16'h0000, 16'h0000, 16'h0000, 16'hFF00}, -1, none};
        vecs[5] = '{1'b0, 28'h20010, 5'd31, none, '0, -1,
                    mk4({{8{8'h55}}, {8{8'h11}}}, {{15{8'h22}}, 8'hFF}, {16{8'h33}}, {16{8'h44}})};
        vecs[6] = '{1'b1, 28'h3FF, 5'd0,
                    mk4({16{8'hA1}}, {16{8'hB2}}, {16{8'hC3}}, {16{8'hD4}}),
                    {4{16'hFFFF}}, 1, none};
        vecs[7] = '{1'b0, 28'hFFFFFFF, 5'd0, none, '0, -1,
                    mk4({16{8'hA1}}, {16{8'hB2}}, {16{8'hC3}}, {16{8'hD4}})};

        reset = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_rw = 1'b0;
        mem_req_addr = '0;
        mem_req_tag = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits = '0;
        mem_req_data_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {127'b0, mem_req_ready}, 128'd1);
        chk("reset_resp_valid", {127'b0, mem_resp_valid}, 128'd0);
        chk("reset_data_ready", {127'b0, mem_req_data_ready}, 128'd0);
        chk("reset_resp_data", mem_resp_data, 128'd0);
        chk("reset_resp_tag", {123'b0, mem_resp_tag}, 128'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rw) begin
                do_write(vecs[i].addr, vecs[i].d, vecs[i].m, vecs[i].gap_beat);
            end else begin
                issue(1'b0, vecs[i].addr, vecs[i].tag, 1'b1, vecs[i].e, hs1, ok);
                drain();
            end
        end

        // Back-to-back reads: the second request is held valid while the first burst runs.
        issue(1'b0, 28'h10, 5'd1, 1'b0, none, hs1, ok);
        issue(1'b0, 28'h10, 5'd2, 1'b0, none, hs2, ok);
`ifndef MEM_BACKPRESSURE_EN
        chk("b2b_accept_cycle", 128'(hs2 - hs1), 128'(L + 4));
`endif
        drain();

        // Reset lands while beat 2 is on the bus.
        issue(1'b0, 28'h3FF, 5'd7, 1'b0, none, hs3, ok);
        while (cyc < hs3 + L + 1) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_burst_resp_valid", {127'b0, mem_resp_valid}, 128'd0);
        chk("rst_burst_req_ready", {127'b0, mem_req_ready}, 128'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 28'h10, 5'd9, 1'b0, none, hs3, ok);
        drain();

        // Random traffic over eight lines with aliasing upper address bits.
        for (int i = 0; i < 8; i++) begin
            lines[i] = 10'(i * 131 + 7);
            do_write({18'($urandom), lines[i]}, mk4(rnd128(), rnd128(), rnd128(), rnd128()),
                     {4{16'hFFFF}}, -1);
        end
        for (int op = 0; op < 200; op++) begin
            logic [27:0] a;
            a = {18'($urandom), lines[$urandom % 8]};
            if ($urandom % 2 == 1) begin
                logic [3:0][15:0] m;
                for (int b = 0; b < 4; b++) begin
                    case ($urandom % 4)
                        0: m[b] = 16'h0000;
                        1: m[b] = 16'hFFFF;
                        default: m[b] = 16'($urandom);
                    endcase
                end
                do_write(a, mk4(rnd128(), rnd128(), rnd128(), rnd128()), m,
                         ($urandom % 3 == 0) ? int'($urandom % 4) : -1);
            end else begin
                issue(1'b0, a, 5'($urandom), 1'b0, none, hs1, ok);
                if ($urandom % 4 == 0) drain();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
